enum_level_stepper: RTL
=======================

ENUM_LEVEL_STEPPER -- requirements
Module: enum_level_stepper

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent level channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of the step-count field.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap at ends, 1 = hold at ends.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 Command ports SHALL be: cmd_valid in 1; cmd_ready out 1; cmd_ch in $clog2(NUM_CH) (min 1); cmd_op in stepper_op_e; cmd_count in CNT_W; cmd_raw in 8, raw value for LOAD.
REQ-006 Response ports SHALL be: rsp_valid out 1; rsp_ready in 1; rsp_ch out as cmd_ch; rsp_level out level_e; rsp_edge out 1, wrap or saturation occurred; rsp_invalid out 1, LOAD raw was not a member.
REQ-007 Status ports SHALL be: level_out out level_e[NUM_CH], current level per channel; num_levels out int, constant 5.

Function
REQ-008 Member order SHALL be E_NONE(0), E_LOW(10), E_MEDIUM(20), E_HIGH(30), E_MAX(40); first = E_NONE, last = E_MAX.
REQ-009 Ops SHALL be: NEXT = step forward; PREV = step backward; LOAD = set from cmd_raw; QUERY = no change.
REQ-010 FSM SHALL have states IDLE, STEP and RESP; cmd_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-011 IDLE: on cmd_valid & cmd_ready, latch ch/op/count; NEXT/PREV with count > 0 -> STEP; all other cases -> RESP.
REQ-012 STEP: each cycle, move the selected channel one member in the direction and decrement remaining; the edge that reaches remaining = 0 moves the FSM to RESP.
REQ-013 Latency: rsp_valid SHALL rise N+1 cycles after the accept edge for step count N (1 cycle for count 0, LOAD or QUERY).
REQ-014 Wrap mode: NEXT from E_MAX gives E_NONE and PREV from E_NONE gives E_MAX; each such step sets the edge flag.
REQ-015 Saturate mode: NEXT at E_MAX and PREV at E_NONE hold the level and set the edge flag; remaining steps are still consumed.
REQ-016 LOAD: a member value SHALL be stored with rsp_invalid = 0; a non-member value stores E_NONE with rsp_invalid = 1.
REQ-017 RESP: rsp_ch, rsp_level, rsp_edge and rsp_invalid SHALL be stable while rsp_valid & !rsp_ready; rsp_valid & rsp_ready -> IDLE.
REQ-018 The edge and invalid flags SHALL clear on command accept.
REQ-019 level_out SHALL update every STEP cycle; unselected channels SHALL never change.
REQ-020 cmd_ch >= NUM_CH SHALL be treated as QUERY on channel 0 with rsp_invalid = 1.

Reset
REQ-021 On rst, the FSM SHALL go to IDLE, all level_out = E_NONE, rsp_valid = 0, cmd_ready = 1 on the following cycle, flags = 0, rsp_ch = 0, rsp_level = E_NONE.
REQ-022 rst during STEP or RESP SHALL abort the operation with no response emitted; rst has priority over all other inputs.

Configuration
REQ-023 With ENUM_STEPPER_WRAP_CNT_EN defined, the block SHALL add output wrap_cnt, logic [15:0][NUM_CH].
REQ-024 wrap_cnt SHALL increment once per edge event on its channel, saturate at 16'hFFFF and reset to 0.
REQ-025 Without ENUM_STEPPER_WRAP_CNT_EN, the port and its counters SHALL be absent; all other behaviour is identical.

Structure
REQ-026 Package enum_types SHALL hold level_e, stepper_op_e (2-bit), stepper_state_e and constant LEVEL_NUM = 5.
REQ-027 Sub-module enum_level_step SHALL be combinational.
REQ-028 enum_level_step inputs SHALL be level, dir and saturate; outputs SHALL be next level and edge.
REQ-029 enum_level_step SHALL be instantiated once, on the selected channel.

Verification
REQ-030 Reset, then NEXT ch1 count 3 -> rsp_valid 4 cycles after accept, rsp_level E_HIGH, rsp_edge 0, level_out[1] = E_HIGH.
REQ-031 Wrap mode: E_HIGH, NEXT count 2 -> E_NONE, rsp_edge 1; PREV count 1 from E_NONE -> E_MAX, rsp_edge 1.
REQ-032 SATURATE = 1: E_MEDIUM, NEXT count 5 -> E_MAX, rsp_edge 1, response 6 cycles after accept.
REQ-033 LOAD raw 20 -> E_MEDIUM, invalid 0; LOAD raw 15 -> E_NONE, invalid 1; QUERY returns without change.
REQ-034 Hold rsp_ready low 3 cycles -> response stable, cmd_ready 0; rst asserted mid-STEP of count 10 -> no response, all levels E_NONE.
REQ-035 With ENUM_STEPPER_WRAP_CNT_EN: NEXT count 10 from E_NONE -> wrap_cnt = 2, level E_NONE.

Source files
------------

// File: rtl/enum_level_stepper_pkg.sv
// enum_types: shared types for the enum level stepper.
//   level_e         : ordered level members E_NONE..E_MAX (values 0,10,20,30,40)
//   stepper_op_e    : 2-bit command opcode (NEXT, PREV, LOAD, QUERY)
//   stepper_state_e : control FSM states (IDLE, STEP, RESP)
//   LEVEL_NUM       : number of level members
//   is_member()     : true when a raw byte is the value of a level member
package enum_types;

    typedef enum logic [7:0] {
        E_NONE   = 8'd0,
        E_LOW    = 8'd10,
        E_MEDIUM = 8'd20,
        E_HIGH   = 8'd30,
        E_MAX    = 8'd40
    } level_e;

    typedef enum logic [1:0] {
        OP_NEXT  = 2'd0,
        OP_PREV  = 2'd1,
        OP_LOAD  = 2'd2,
        OP_QUERY = 2'd3
    } stepper_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_RESP = 2'd2
    } stepper_state_e;

    localparam int     LEVEL_NUM   = 5;
    localparam level_e LEVEL_FIRST = E_NONE;
    localparam level_e LEVEL_LAST  = E_MAX;

    function automatic logic is_member(input logic [7:0] raw);
        case (raw)
            8'd0, 8'd10, 8'd20, 8'd30, 8'd40: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/enum_level_stepper_step.sv
// enum_level_step: combinational single-member step of a level.
//   level      in  : current level
//   dir        in  : 1 = forward (towards E_MAX), 0 = backward (towards E_NONE)
//   saturate   in  : 1 = hold at the ends, 0 = wrap around
//   next_level out : level after one step
//   at_edge    out : the step crossed an end (wrapped or was held)
module enum_level_step
    import enum_types::*;
(
    input  level_e level,
    input  logic   dir,
    input  logic   saturate,
    output level_e next_level,
    output logic   at_edge
);

    always_comb begin
        next_level = level;
        at_edge    = 1'b0;
        if (dir) begin
            case (level)
                E_NONE:   next_level = E_LOW;
                E_LOW:    next_level = E_MEDIUM;
                E_MEDIUM: next_level = E_HIGH;
                E_HIGH:   next_level = E_MAX;
                E_MAX: begin
                    at_edge    = 1'b1;
                    next_level = saturate ? LEVEL_LAST : LEVEL_FIRST;
                end
                default:  next_level = E_NONE;
            endcase
        end else begin
            case (level)
                E_NONE: begin
                    at_edge    = 1'b1;
                    next_level = saturate ? LEVEL_FIRST : LEVEL_LAST;
                end
                E_LOW:    next_level = E_NONE;
                E_MEDIUM: next_level = E_LOW;
                E_HIGH:   next_level = E_MEDIUM;
                E_MAX:    next_level = E_HIGH;
                default:  next_level = E_NONE;
            endcase
        end
    end

endmodule

// File: rtl/enum_level_stepper.sv
// enum_level_stepper: NUM_CH independent enum level channels driven by a
// command/response handshake. NEXT/PREV walk the selected channel one member
// per cycle for cmd_count cycles, LOAD sets it from a raw byte, QUERY reads it.
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only while idle)
//   cmd_ch/op/count/raw : channel, opcode, step count, raw LOAD value
//   rsp_valid/rsp_ready : response handshake (valid only in RESP)
//   rsp_ch/level        : channel and its level after the command
//   rsp_edge            : a wrap or saturation occurred during the command
//   rsp_invalid         : LOAD raw was not a member, or cmd_ch was out of range
//   level_out           : current level of every channel
//   num_levels          : constant member count
// Optional: define ENUM_STEPPER_WRAP_CNT_EN to add wrap_cnt, a per-channel
// saturating 16-bit count of edge events.
module enum_level_stepper
    import enum_types::*;
#(
    parameter  int NUM_CH   = 4,
    parameter  int CNT_W    = 8,
    parameter  int SATURATE = 0,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [CH_W-1:0]          cmd_ch,
    input  stepper_op_e              cmd_op,
    input  logic [CNT_W-1:0]         cmd_count,
    input  logic [7:0]               cmd_raw,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [CH_W-1:0]          rsp_ch,
    output level_e                   rsp_level,
    output logic                     rsp_edge,
    output logic                     rsp_invalid,
    output level_e [NUM_CH-1:0]      level_out,
    output int                       num_levels
`ifdef ENUM_STEPPER_WRAP_CNT_EN
    ,
    output logic [NUM_CH-1:0][15:0]  wrap_cnt
`endif
);

    stepper_state_e      state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    stepper_op_e         op_q, op_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic                edge_q, edge_d;
    logic                invalid_q, invalid_d;
    level_e [NUM_CH-1:0] level_q, level_d;

    level_e              step_next;
    logic                step_edge;
    logic                ch_oob;

    // Single stepper shared by all channels; only the latched channel moves.
    enum_level_step u_step (
        .level      (level_q[ch_q]),
        .dir        (op_q == OP_NEXT),
        .saturate   (SATURATE != 0),
        .next_level (step_next),
        .at_edge    (step_edge)
    );

    assign ch_oob = (32'(cmd_ch) >= 32'(NUM_CH));

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        op_d        = op_q;
        remaining_d = remaining_q;
        edge_d      = edge_q;
        invalid_d   = invalid_q;
        level_d     = level_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    edge_d      = 1'b0;
                    invalid_d   = 1'b0;
                    remaining_d = cmd_count;
                    if (ch_oob) begin
                        // Out-of-range channel degrades to a flagged QUERY of channel 0.
                        ch_d      = '0;
                        op_d      = OP_QUERY;
                        invalid_d = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        ch_d = cmd_ch;
                        op_d = cmd_op;
                        case (cmd_op)
                            OP_NEXT, OP_PREV: begin
                                state_d = (cmd_count != '0) ? ST_STEP : ST_RESP;
                            end
                            OP_LOAD: begin
                                if (is_member(cmd_raw)) begin
                                    level_d[cmd_ch] = level_e'(cmd_raw);
                                end else begin
                                    level_d[cmd_ch] = E_NONE;
                                    invalid_d       = 1'b1;
                                end
                                state_d = ST_RESP;
                            end
                            default: state_d = ST_RESP;
                        endcase
                    end
                end
            end
            ST_STEP: begin
                level_d[ch_q] = step_next;
                edge_d        = edge_q | step_edge;
                remaining_d   = remaining_q - 1'b1;
                if (remaining_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            op_q        <= OP_QUERY;
            remaining_q <= '0;
            edge_q      <= 1'b0;
            invalid_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                level_q[i] <= E_NONE;
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            op_q        <= op_d;
            remaining_q <= remaining_d;
            edge_q      <= edge_d;
            invalid_q   <= invalid_d;
            level_q     <= level_d;
        end
    end

`ifdef ENUM_STEPPER_WRAP_CNT_EN
    logic [NUM_CH-1:0][15:0] wrap_cnt_q, wrap_cnt_d;

    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if ((state_q == ST_STEP) && step_edge && (wrap_cnt_q[ch_q] != 16'hFFFF)) begin
            wrap_cnt_d[ch_q] = wrap_cnt_q[ch_q] + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_cnt_q <= '0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign wrap_cnt = wrap_cnt_q;
`endif

    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_ch      = ch_q;
    assign rsp_level   = level_q[ch_q];
    assign rsp_edge    = edge_q;
    assign rsp_invalid = invalid_q;
    assign level_out   = level_q;
    assign num_levels  = LEVEL_NUM;

endmodule
